joybus_port_scheduler: RTL

Host-side Joybus sequencer that shares one bit-level transmit/receive engine among four controller ports. On `start` it walks the enabled ports in ascending order, sends one command byte plus stop bit on each port's one-wire line, captures the controller's reply, and reports each result on a single response bus. It sits between the PIF command logic and the four port pads, and is the master counterpart of the controller-side responder.

---
 rtl/joybus_pkg.sv | 44 ++++
 rtl/joybus_bit_timer.sv | 28 ++
 rtl/joybus_port_scheduler.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/joybus_pkg.sv
// Shared types, command codes and timing helpers for the Joybus host scheduler.
package joybus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SELECT,
    ST_TX_LOW,
    ST_TX_HIGH,
    ST_STOP_LOW,
    ST_RX_WAIT,
    ST_RX_SAMPLE,
    ST_RX_RISE,
    ST_RX_STOP,
    ST_REPORT,
    ST_GAP,
    ST_DONE
  } jb_state_e;

  localparam logic [7:0] JB_CMD_INFO  = 8'h00;
  localparam logic [7:0] JB_CMD_POLL  = 8'h01;
  localparam logic [7:0] JB_CMD_RESET = 8'hFF;

  localparam int unsigned JB_BIT_US      = 4;
  localparam int unsigned JB_ZERO_LOW_US = 3;
  localparam int unsigned JB_ONE_LOW_US  = 1;
  localparam int unsigned JB_STOP_LOW_US = 1;
  localparam int unsigned JB_SAMPLE_US   = 2;
  localparam int unsigned JB_TIMER_W     = 16;

  function automatic logic [5:0] jb_reply_bits(input logic [7:0] c);
    case (c)
      JB_CMD_INFO, JB_CMD_RESET: return 6'd24;
      JB_CMD_POLL:               return 6'd32;
      default:                   return 6'd32;
    endcase
  endfunction

  // Timer load value for a state that must last exactly us*clks cycles.
  function automatic logic [JB_TIMER_W-1:0] jb_load(input int unsigned us,
                                                     input int unsigned clks);
    return JB_TIMER_W'(us * clks - 1);
  endfunction

endpackage

// File: rtl/joybus_bit_timer.sv
// Loadable down-counter shared by TX cell timing, RX sampling, timeouts and the gap.
module joybus_bit_timer
  import joybus_pkg::*;
#(
  parameter int unsigned W = JB_TIMER_W
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/joybus_port_scheduler.sv
// Joybus host sequencer: walks enabled ports, sends one command byte each and
// collects the reply through one shared bit engine.
module joybus_port_scheduler
  import joybus_pkg::*;
#(
  parameter int unsigned CLKS_PER_US = 50,
  parameter int unsigned TIMEOUT_US  = 64,
  parameter int unsigned GAP_US      = 16
) (
  input  logic        clock,
  input  logic        reset_l,
  input  logic        start,
  input  logic [3:0]  port_enable,
  input  logic [7:0]  cmd,
  input  logic [3:0]  joy_in,
  output logic [3:0]  joy_drive_low,
  output logic        busy,
  output logic        done,
  output logic        resp_valid,
  output logic [1:0]  resp_port,
  output logic [31:0] resp_data,
  output logic        resp_timeout
);

  localparam logic [JB_TIMER_W-1:0] T_ZERO_LOW  = jb_load(JB_ZERO_LOW_US, CLKS_PER_US);
  localparam logic [JB_TIMER_W-1:0] T_ONE_LOW   = jb_load(JB_ONE_LOW_US, CLKS_PER_US);
  localparam logic [JB_TIMER_W-1:0] T_ZERO_HIGH = jb_load(JB_BIT_US - JB_ZERO_LOW_US, CLKS_PER_US);
  localparam logic [JB_TIMER_W-1:0] T_ONE_HIGH  = jb_load(JB_BIT_US - JB_ONE_LOW_US, CLKS_PER_US);
  localparam logic [JB_TIMER_W-1:0] T_STOP_LOW  = jb_load(JB_STOP_LOW_US, CLKS_PER_US);
  localparam logic [JB_TIMER_W-1:0] T_SAMPLE    = jb_load(JB_SAMPLE_US, CLKS_PER_US);
  localparam logic [JB_TIMER_W-1:0] T_TIMEOUT   = jb_load(TIMEOUT_US, CLKS_PER_US);
  localparam logic [JB_TIMER_W-1:0] T_GAP       = jb_load(GAP_US, CLKS_PER_US);

  jb_state_e        state_q, state_d;
  logic [3:0]       remaining_q, remaining_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [1:0]       port_q, port_d;
  logic [5:0]       bits_q, bits_d;
  logic [5:0]       reply_len_q, reply_len_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic [31:0]      rx_q, rx_d;
  logic             stop_seen_q, stop_seen_d;
  logic [3:0]       drive_q, drive_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             resp_valid_q, resp_valid_d;
  logic [1:0]       resp_port_q, resp_port_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic             resp_timeout_q, resp_timeout_d;

  logic             sync1_q, sync2_q, prev_q;
  logic             fall;
  logic             tmr_load;
  logic [JB_TIMER_W-1:0] tmr_value;
  logic             tmr_expired;
  logic             sel_found;
  logic [1:0]       sel_port;
  logic             rpt_ok, rpt_to;

  // Only the selected port's pad is observed; idle lines read high.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= joy_in[port_q];
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall = prev_q & ~sync2_q;

  joybus_bit_timer #(.W(JB_TIMER_W)) u_timer (
    .clk_i     (clock),
    .rst_n_i   (reset_l),
    .load_i    (tmr_load),
    .value_i   (tmr_value),
    .expired_o (tmr_expired)
  );

  always_comb begin
    sel_found = 1'b0;
    sel_port  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!sel_found && remaining_q[i]) begin
        sel_found = 1'b1;
        sel_port  = 2'(i);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    cmd_d          = cmd_q;
    port_d         = port_q;
    bits_d         = bits_q;
    reply_len_d    = reply_len_q;
    tx_sh_d        = tx_sh_q;
    rx_d           = rx_q;
    stop_seen_d    = stop_seen_q;
    drive_d        = drive_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    resp_valid_d   = 1'b0;
    resp_port_d    = resp_port_q;
    resp_data_d    = resp_data_q;
    resp_timeout_d = resp_timeout_q;
    tmr_load       = 1'b0;
    tmr_value      = '0;
    rpt_ok         = 1'b0;
    rpt_to         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = port_enable;
          cmd_d       = cmd;
          busy_d      = 1'b1;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (sel_found) begin
          port_d                = sel_port;
          remaining_d[sel_port] = 1'b0;
          tx_sh_d               = cmd_q;
          bits_d                = '0;
          drive_d               = 4'b0001 << sel_port;
          tmr_load              = 1'b1;
          tmr_value             = cmd_q[7] ? T_ONE_LOW : T_ZERO_LOW;
          state_d               = ST_TX_LOW;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_TX_LOW: begin
        if (tmr_expired) begin
          drive_d   = '0;
          tmr_load  = 1'b1;
          tmr_value = tx_sh_q[7] ? T_ONE_HIGH : T_ZERO_HIGH;
          state_d   = ST_TX_HIGH;
        end
      end
      ST_TX_HIGH: begin
        if (tmr_expired) begin
          drive_d  = 4'b0001 << port_q;
          tmr_load = 1'b1;
          if (bits_q == 6'd7) begin
            tmr_value = T_STOP_LOW;
            state_d   = ST_STOP_LOW;
          end else begin
            tx_sh_d   = {tx_sh_q[6:0], 1'b0};
            bits_d    = bits_q + 6'd1;
            tmr_value = tx_sh_q[6] ? T_ONE_LOW : T_ZERO_LOW;
            state_d   = ST_TX_LOW;
          end
        end
      end
      ST_STOP_LOW: begin
        if (tmr_expired) begin
          drive_d     = '0;
          bits_d      = '0;
          rx_d        = '0;
          stop_seen_d = 1'b0;
          reply_len_d = jb_reply_bits(cmd_q);
          tmr_load    = 1'b1;
          tmr_value   = T_TIMEOUT;
          state_d     = ST_RX_WAIT;
        end
      end
      ST_RX_WAIT: begin
        if (fall) begin
          tmr_load  = 1'b1;
          tmr_value = T_SAMPLE;
          state_d   = ST_RX_SAMPLE;
        end else if (tmr_expired) begin
          rpt_to = 1'b1;
        end
      end
      ST_RX_SAMPLE: begin
        if (tmr_expired) begin
          rx_d      = {rx_q[30:0], sync2_q};
          bits_d    = bits_q + 6'd1;
          tmr_load  = 1'b1;
          tmr_value = T_TIMEOUT;
          state_d   = ST_RX_RISE;
        end
      end
      ST_RX_RISE: begin
        if (sync2_q) begin
          tmr_load  = 1'b1;
          tmr_value = T_TIMEOUT;
          state_d   = (bits_q == reply_len_q) ? ST_RX_STOP : ST_RX_WAIT;
        end else if (tmr_expired) begin
          rpt_to = 1'b1;
        end
      end
      ST_RX_STOP: begin
        // Every data bit is in hand, so a missing controller stop bit is tolerated.
        if (tmr_expired) begin
          rpt_ok = 1'b1;
        end else if (!stop_seen_q && fall) begin
          stop_seen_d = 1'b1;
          tmr_load    = 1'b1;
          tmr_value   = T_TIMEOUT;
        end else if (stop_seen_q && sync2_q) begin
          rpt_ok = 1'b1;
        end
      end
      ST_REPORT: begin
        tmr_load  = 1'b1;
        tmr_value = T_GAP;
        state_d   = ST_GAP;
      end
      ST_GAP: begin
        if (tmr_expired) begin
          if (remaining_q != '0) begin
            state_d = ST_SELECT;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (rpt_ok || rpt_to) begin
      resp_valid_d   = 1'b1;
      resp_port_d    = port_q;
      resp_timeout_d = rpt_to;
      resp_data_d    = rpt_to ? '0 : rx_q;
      state_d        = ST_REPORT;
    end
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q        <= ST_IDLE;
      remaining_q    <= '0;
      cmd_q          <= '0;
      port_q         <= '0;
      bits_q         <= '0;
      reply_len_q    <= '0;
      tx_sh_q        <= '0;
      rx_q           <= '0;
      stop_seen_q    <= 1'b0;
      drive_q        <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_port_q    <= '0;
      resp_data_q    <= '0;
      resp_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      cmd_q          <= cmd_d;
      port_q         <= port_d;
      bits_q         <= bits_d;
      reply_len_q    <= reply_len_d;
      tx_sh_q        <= tx_sh_d;
      rx_q           <= rx_d;
      stop_seen_q    <= stop_seen_d;
      drive_q        <= drive_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      resp_valid_q   <= resp_valid_d;
      resp_port_q    <= resp_port_d;
      resp_data_q    <= resp_data_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

  assign joy_drive_low = drive_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign resp_valid    = resp_valid_q;
  assign resp_port     = resp_port_q;
  assign resp_data     = resp_data_q;
  assign resp_timeout  = resp_timeout_q;

endmodule
